lm32_seq_divider: RTL and testbench
===================================

LM32_SEQ_DIVIDER -- requirements
Module: lm32_seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (even, >= 4).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start_x, input, 1, single-cycle request to begin a division.
REQ-005 The block SHALL have port sign_x, input, 1, sampled with start_x: 1 = signed two's-complement, 0 = unsigned.
REQ-006 The block SHALL have port rem_x, input, 1, sampled with start_x: 1 = return remainder, 0 = return quotient.
REQ-007 The block SHALL have port operand_0_x, input, WIDTH, the dividend.
REQ-008 The block SHALL have port operand_1_x, input, WIDTH, the divisor.
REQ-009 The block SHALL have port kill_x, input, 1, which aborts any operation in progress.
REQ-010 The block SHALL have port result_x, output, WIDTH, the registered quotient or remainder.
REQ-011 The block SHALL have port busy_x, output, 1, high while in DIVIDE or FIX.
REQ-012 The block SHALL have port done_x, output, 1, a one-cycle pulse marking result_x valid.
REQ-013 The block SHALL have port divide_by_zero_x, output, 1, high with done_x when the divisor was zero.

Function
REQ-014 The FSM SHALL have states IDLE, DIVIDE and FIX.
REQ-015 In IDLE, start_x=1 with kill_x=0 SHALL latch sign_x, rem_x, the operand signs and the operand magnitudes (absolute values when sign_x=1, raw values otherwise), load the bit counter with WIDTH-1, clear the partial remainder, and go to DIVIDE.
REQ-016 In IDLE, start_x=1 with operand_1_x=0 SHALL instead stay in IDLE and, on the next edge, pulse done_x=1 and divide_by_zero_x=1 with result_x=0.
REQ-017 Each DIVIDE cycle SHALL perform one restoring step: shift {remainder, quotient} left by 1, subtract the divisor magnitude from the remainder, keep the difference and set quotient LSB=1 if there is no borrow, otherwise keep the shifted remainder and set LSB=0.
REQ-018 The counter SHALL decrement each DIVIDE cycle; the step taken at count 0 SHALL be the last, after which the FSM goes to FIX (exactly WIDTH DIVIDE cycles).
REQ-019 FIX SHALL negate the quotient when signed and the operand signs differ, and SHALL negate the remainder when signed and the dividend was negative.
REQ-020 FIX SHALL register the selected value into result_x, pulse done_x for one cycle, and return to IDLE.
REQ-021 Latency SHALL be WIDTH+2 edges from the edge sampling start_x to the edge asserting done_x (34 for WIDTH=32).
REQ-022 Signed most-negative / -1 SHALL yield quotient 2^(WIDTH-1) (0x80000000) and remainder 0, without flagging an error.
REQ-023 start_x SHALL be ignored while busy_x=1.
REQ-024 kill_x=1 in any state SHALL force IDLE on the next edge, with no done_x pulse and result_x unchanged; kill_x wins over a simultaneous start_x.
REQ-025 result_x SHALL hold its value between done_x pulses; divide_by_zero_x SHALL be high only in the done_x cycle.
REQ-026 Signedness SHALL affect only magnitude extraction and the FIX correction; the datapath SHALL be WIDTH+1 bits wide to capture the borrow.

Reset
REQ-027 While rst_n_i=0, the block SHALL asynchronously force state IDLE, counter 0, internal registers 0, result_x=0, busy_x=0, done_x=0 and divide_by_zero_x=0.
REQ-028 Assertion of rst_n_i mid-operation SHALL abort it with no done_x pulse; release SHALL be synchronous to clk_i.

Verification
REQ-029 Unsigned 100/7 with rem_x=0 -> done_x 34 edges later, result_x=14, busy_x high for exactly 33 cycles; with rem_x=1 -> result_x=2.
REQ-030 Signed -7/2 -> quotient 0xFFFFFFFD; with rem_x=1 -> 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-031 Divisor 0 (dividend 0x12345678) -> done_x and divide_by_zero_x high one edge later, result_x=0, busy_x never high.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> result_x=0x80000000, divide_by_zero_x=0; unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-033 kill_x at DIVIDE cycle 10, then start_x of 9/3 -> no done_x for the first operation, result_x=3 for the second; a start_x issued while busy is ignored.
REQ-034 rst_n_i pulsed low mid-DIVIDE -> all outputs 0 immediately, no done_x pulse, and the next start_x completes normally.

Source files
------------

// File: rtl/lm32_seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed/unsigned,
// quotient or remainder select, abortable via kill_x.
module lm32_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_x,
  input  logic             sign_x,
  input  logic             rem_x,
  input  logic [WIDTH-1:0] operand_0_x,
  input  logic [WIDTH-1:0] operand_1_x,
  input  logic             kill_x,
  output logic [WIDTH-1:0] result_x,
  output logic             busy_x,
  output logic             done_x,
  output logic             divide_by_zero_x,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIX    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_q, sign_d;
  logic             rem_sel_q, rem_sel_d;
  logic             neg0_q, neg0_d;
  logic             neg1_q, neg1_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             div_zero;
  logic             op0_neg, op1_neg;
  logic [WIDTH-1:0] mag0, mag1;
  logic [WIDTH:0]   shifted, diff;
  logic             borrow;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign div_zero = (operand_1_x == '0);
  assign op0_neg  = sign_x & operand_0_x[WIDTH-1];
  assign op1_neg  = sign_x & operand_1_x[WIDTH-1];
  assign mag0     = op0_neg ? (~operand_0_x + 1'b1) : operand_0_x;
  assign mag1     = op1_neg ? (~operand_1_x + 1'b1) : operand_1_x;

  // One restoring step; bit WIDTH of the difference is the borrow.
  assign shifted  = {rem_q, quot_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor_q};
  assign borrow   = diff[WIDTH];

  assign quot_fix = (sign_q & (neg0_q ^ neg1_q)) ? (~quot_q + 1'b1) : quot_q;
  assign rem_fix  = (sign_q & neg0_q) ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill_x) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_x && !div_zero) state_d = ST_DIVIDE;
        ST_DIVIDE: if (cnt_q == '0) state_d = ST_FIX;
        ST_FIX:    state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    sign_d    = sign_q;
    rem_sel_d = rem_sel_q;
    neg0_d    = neg0_q;
    neg1_d    = neg1_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    if (!kill_x) begin
      case (state_q)
        ST_IDLE: begin
          if (start_x && div_zero) begin
            done_d   = 1'b1;
            dbz_d    = 1'b1;
            result_d = '0;
          end else if (start_x) begin
            sign_d    = sign_x;
            rem_sel_d = rem_x;
            neg0_d    = op0_neg;
            neg1_d    = op1_neg;
            quot_d    = mag0;
            divisor_d = mag1;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH - 1);
          end
        end
        ST_DIVIDE: begin
          rem_d  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], ~borrow};
          cnt_d  = cnt_q - 1'b1;
        end
        ST_FIX: begin
          result_d = rem_sel_q ? rem_fix : quot_fix;
          done_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      sign_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      neg0_q    <= 1'b0;
      neg1_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      sign_q    <= sign_d;
      rem_sel_q <= rem_sel_d;
      neg0_q    <= neg0_d;
      neg1_q    <= neg1_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign result_x         = result_q;
  assign done_x           = done_q;
  assign divide_by_zero_x = dbz_q;
  assign busy_x           = (state_q == ST_DIVIDE) || (state_q == ST_FIX);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_lm32_seq_divider.sv
// Directed and randomized checks of lm32_seq_divider against a 64-bit
// arithmetic reference model.
module tb_lm32_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_x = 1'b0;
  logic         sign_x = 1'b0;
  logic         rem_x = 1'b0;
  logic [W-1:0] operand_0_x = '0;
  logic [W-1:0] operand_1_x = '0;
  logic         kill_x = 1'b0;
  logic [W-1:0] result_x;
  logic         busy_x;
  logic         done_x;
  logic         divide_by_zero_x;
  logic [1:0]   dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  lm32_seq_divider #(.WIDTH(W)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .start_x          (start_x),
    .sign_x           (sign_x),
    .rem_x            (rem_x),
    .operand_0_x      (operand_0_x),
    .operand_1_x      (operand_1_x),
    .kill_x           (kill_x),
    .result_x         (result_x),
    .busy_x           (busy_x),
    .done_x           (done_x),
    .divide_by_zero_x (divide_by_zero_x),
    .dbg_state_o      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: divide in 64-bit signed arithmetic (truncating), take low W bits.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sg, input logic rm);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    sa = sg ? {{32{a[W-1]}}, a} : {32'h0, a};
    sb = sg ? {{32{b[W-1]}}, b} : {32'h0, b};
    q = sa / sb;
    r = sa % sb;
    return rm ? r[W-1:0] : q[W-1:0];
  endfunction

  // Issue one division; optionally inject a stray start (9/3) at cycle stray_at.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input logic rm, input logic [W-1:0] exp, input string tag,
                       input int stray_at);
    int edges, busy_cnt;
    logic [W-1:0] held;
    @(negedge clk);
    start_x = 1'b1; sign_x = sg; rem_x = rm; operand_0_x = a; operand_1_x = b;
    busy_cnt = 0;
    for (edges = 1; edges <= 60; edges++) begin
      @(negedge clk);
      start_x = 1'b0;
      if (busy_x) busy_cnt++;
      if (done_x) break;
      if (edges == stray_at) begin
        start_x = 1'b1; sign_x = 1'b0; rem_x = 1'b0;
        operand_0_x = 32'd9; operand_1_x = 32'd3;
      end
    end
    chk({tag, "_latency"}, edges, (b == '0) ? 1 : 34);
    chk({tag, "_result"}, result_x, exp);
    chk({tag, "_dbz"}, {31'b0, divide_by_zero_x}, {31'b0, (b == '0)});
    chk({tag, "_busy_cycles"}, busy_cnt, (b == '0) ? 0 : 33);
    held = result_x;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'b0, done_x, divide_by_zero_x}, 32'd0);
    chk({tag, "_hold"}, result_x, held);
  endtask

  // Count done pulses over n cycles.
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_x) pulses++;
    end
  endtask

  initial begin
    int pulses;
    logic [W-1:0] a, b, prev;
    logic sg, rm;

    repeat (2) @(negedge clk);
    chk("reset_result", result_x, '0);
    chk("reset_flags", {29'b0, busy_x, done_x, divide_by_zero_x}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_flags", {29'b0, busy_x, done_x, divide_by_zero_x}, 32'd0);

    do_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "u100_7_q", 0);
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, "u100_7_r", 0);
    do_op(-32'sd7, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, "s-7_2_q", 0);
    do_op(-32'sd7, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, "s-7_2_r", 0);
    do_op(32'd7, -32'sd2, 1'b1, 1'b0, 32'hFFFF_FFFD, "s7_-2_q", 0);
    do_op(32'd7, -32'sd2, 1'b1, 1'b1, 32'd1, "s7_-2_r", 0);
    do_op(32'd50, 32'd5, 1'b0, 1'b0, 32'd10, "u50_5_q", 0);
    do_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'd0, "div_zero", 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, "smin_-1_q", 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, "smin_-1_r", 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, "umax_1_q", 0);
    do_op(32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, "stray_start", 3);

    // Kill at DIVIDE cycle 10: no done, result unchanged.
    prev = result_x;
    @(negedge clk);
    start_x = 1'b1; sign_x = 1'b0; rem_x = 1'b0; operand_0_x = 32'd77; operand_1_x = 32'd5;
    @(negedge clk);
    start_x = 1'b0;
    repeat (9) @(negedge clk);
    kill_x = 1'b1;
    @(negedge clk);
    kill_x = 1'b0;
    chk("kill_busy", {31'b0, busy_x}, 32'd0);
    count_done(40, pulses);
    chk("kill_no_done", pulses, 0);
    chk("kill_result_held", result_x, prev);
    do_op(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, "after_kill", 0);

    // kill_x wins over a simultaneous start_x.
    @(negedge clk);
    start_x = 1'b1; kill_x = 1'b1; operand_0_x = 32'd20; operand_1_x = 32'd4;
    @(negedge clk);
    start_x = 1'b0; kill_x = 1'b0;
    chk("kill_start_busy", {31'b0, busy_x}, 32'd0);
    count_done(40, pulses);
    chk("kill_start_no_done", pulses, 0);

    // Asynchronous reset mid-DIVIDE.
    @(negedge clk);
    start_x = 1'b1; sign_x = 1'b0; rem_x = 1'b0; operand_0_x = 32'd100; operand_1_x = 32'd7;
    @(negedge clk);
    start_x = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_result", result_x, '0);
    chk("rst_mid_flags", {29'b0, busy_x, done_x, divide_by_zero_x}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, pulses);
    chk("rst_no_done", pulses, 0);
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "after_rst", 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 50);
        4:       b = -$urandom_range(1, 50);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      sg = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      do_op(a, b, sg, rm, model(a, b, sg, rm), $sformatf("rand%0d", i), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
